stack_sequencer: RTL and testbench

- Downstream consumer of the push/pop bitmasks in the pre-decoded instruction record: PUSH/POP, PUSH R/POP R (all-register push/pop), interrupt/BRK frames, RETI, plus the STACK_OPERAND and STACK_SP_DISCARD cases.
- Walks the set bits of the mask and issues one word bus transfer per bit, relative to SS. Sources/sinks register values through the register file and returns the final SP.
- Sits between the execute sequencer and the bus interface unit.

---
 rtl/stack_sequencer.sv | 145 ++++++++++++++
 tb/tb_stack_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : stack_sequencer
// Brief    : Walks push/pop bitmasks, one SS-relative word transfer per bit.
// Revision : 1.0
// ============================================================================
module stack_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] push_mask,
    input  logic [15:0] pop_mask,
    input  logic [15:0] sp_in,
    input  logic [15:0] operand_in,
    output logic [3:0]  reg_sel,
    input  logic [15:0] reg_rdata,
    output logic        reg_we,
    output logic [15:0] reg_wdata,
    output logic [15:0] operand_out,
    output logic        operand_valid,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        busy,
    output logic        done,
    output logic [15:0] sp_out,
    output logic        sp_we
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_PUSH   = 2'd1;
    localparam logic [1:0] S_POP    = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [3:0] C_BIT_SP      = 4'd4;
    localparam logic [3:0] C_BIT_DISCARD = 4'd5;
    localparam logic [3:0] C_BIT_OPERAND = 4'd15;

    logic [1:0]  r_state;
    logic [15:0] r_push_mask;
    logic [15:0] r_pop_mask;
    logic [15:0] r_sp;
    logic [15:0] r_sp_start;
    logic [15:0] r_operand;
    logic [15:0] r_operand_out;
    logic        r_operand_valid;

    logic [3:0]  w_push_idx;
    logic [3:0]  w_pop_idx;
    logic [15:0] w_push_rest;
    logic [15:0] w_pop_rest;
    logic        w_in_push;
    logic        w_in_pop;

    // Pushes take the lowest set bit first, pops the highest.
    always_comb begin
        w_push_idx = 4'd0;
        w_pop_idx  = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (r_push_mask[i]) w_push_idx = 4'(i);
        end
        for (int i = 0; i < 16; i++) begin
            if (r_pop_mask[i]) w_pop_idx = 4'(i);
        end
    end

    assign w_push_rest = r_push_mask & ~(16'd1 << w_push_idx);
    assign w_pop_rest  = r_pop_mask & ~(16'd1 << w_pop_idx);
    assign w_in_push   = (r_state == S_PUSH);
    assign w_in_pop    = (r_state == S_POP);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_push_mask     <= 16'd0;
            r_pop_mask      <= 16'd0;
            r_sp            <= 16'd0;
            r_sp_start      <= 16'd0;
            r_operand       <= 16'd0;
            r_operand_out   <= 16'd0;
            r_operand_valid <= 1'b0;
        end else begin
            r_operand_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_push_mask <= push_mask;
                        r_pop_mask  <= pop_mask;
                        r_sp        <= sp_in;
                        r_sp_start  <= sp_in;
                        r_operand   <= operand_in;
                        if (push_mask != 16'd0)     r_state <= S_PUSH;
                        else if (pop_mask != 16'd0) r_state <= S_POP;
                        else                        r_state <= S_FINISH;
                    end
                end
                S_PUSH: begin
                    if (mem_ack) begin
                        r_sp        <= r_sp - 16'd2;
                        r_push_mask <= w_push_rest;
                        if (w_push_rest == 16'd0)
                            r_state <= (r_pop_mask != 16'd0) ? S_POP : S_FINISH;
                    end
                end
                S_POP: begin
                    if (mem_ack) begin
                        r_sp       <= r_sp + 16'd2;
                        r_pop_mask <= w_pop_rest;
                        if (w_pop_idx == C_BIT_OPERAND) begin
                            r_operand_out   <= mem_rdata;
                            r_operand_valid <= 1'b1;
                        end
                        if (w_pop_rest == 16'd0) r_state <= S_FINISH;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Bus fields depend only on registered state, so they hold through waits.
    assign mem_req   = w_in_push | w_in_pop;
    assign mem_wr    = w_in_push;
    assign mem_addr  = w_in_push ? (r_sp - 16'd2) : (w_in_pop ? r_sp : 16'd0);
    assign mem_wdata = !w_in_push                   ? 16'd0      :
                       (w_push_idx == C_BIT_SP)      ? r_sp_start :
                       (w_push_idx == C_BIT_OPERAND) ? r_operand  : reg_rdata;

    assign reg_sel   = w_in_push ? w_push_idx : (w_in_pop ? w_pop_idx : 4'd0);
    assign reg_we    = w_in_pop && mem_ack &&
                       (w_pop_idx != C_BIT_DISCARD) && (w_pop_idx != C_BIT_OPERAND);
    assign reg_wdata = reg_we ? mem_rdata : 16'd0;

    assign operand_out   = r_operand_out;
    assign operand_valid = r_operand_valid;
    assign busy          = (r_state != S_IDLE);
    assign done          = (r_state == S_FINISH);
    assign sp_we         = done;
    assign sp_out        = r_sp;

endmodule
`default_nettype wire

// File: tb/tb_stack_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stack_sequencer
// Brief    : Vector table plus transfer/register-write scoreboard for the stack sequencer.
// Revision : 1.0
// ============================================================================
module tb_stack_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] push_mask = 16'd0;
    logic [15:0] pop_mask = 16'd0;
    logic [15:0] sp_in = 16'd0;
    logic [15:0] operand_in = 16'd0;
    logic [3:0]  reg_sel;
    logic [15:0] reg_rdata;
    logic        reg_we;
    logic [15:0] reg_wdata;
    logic [15:0] operand_out;
    logic        operand_valid;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [15:0] mem_rdata = 16'd0;
    logic        busy;
    logic        done;
    logic [15:0] sp_out;
    logic        sp_we;

    stack_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .push_mask(push_mask), .pop_mask(pop_mask),
        .sp_in(sp_in), .operand_in(operand_in),
        .reg_sel(reg_sel), .reg_rdata(reg_rdata),
        .reg_we(reg_we), .reg_wdata(reg_wdata),
        .operand_out(operand_out), .operand_valid(operand_valid),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .busy(busy), .done(done), .sp_out(sp_out), .sp_we(sp_we)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] push_mask;
        logic [15:0] pop_mask;
        logic [15:0] sp_in;
        logic [15:0] operand_in;
        int          waits;
        logic [15:0] exp_sp;
        int          exp_cycles;
        int          exp_opv;
        logic [15:0] exp_op;
        bit          inject;
    } vec_t;

    typedef struct { logic wr; logic [15:0] addr; logic [15:0] data; } xfer_t;
    typedef struct { logic [3:0] sel; logic [15:0] data; } rw_t;

    xfer_t       xq[$];
    rw_t         rq[$];
    logic [15:0] regs [16];
    logic [15:0] mem [65536];
    logic [15:0] model_mem [65536];

    int checks = 0;
    int errors = 0;
    int waits = 0;
    int wcnt = 0;
    bit have_hold = 0;
    logic [32:0] hold_bus;
    int opv_cnt = 0;
    logic [15:0] op_seen;

    assign reg_rdata = regs[reg_sel];

    task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Bus responder with programmable wait states; checks each acked transfer.
    always @(negedge clk) begin
        if (reset || !mem_req) begin
            mem_ack   = 1'b0;
            wcnt      = 0;
            have_hold = 0;
        end else begin
            if (have_hold) check("bus_stable", {mem_wr, mem_addr, mem_wdata}, hold_bus);
            if (wcnt >= waits) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                wcnt      = 0;
                have_hold = 0;
                if (xq.size() == 0) begin
                    check("unexpected_xfer", {mem_wr, mem_addr}, 48'h0);
                end else begin
                    xfer_t e;
                    e = xq.pop_front();
                    check("xfer_wr", mem_wr, e.wr);
                    check("xfer_addr", mem_addr, e.addr);
                    if (e.wr) check("xfer_wdata", mem_wdata, e.data);
                end
                if (mem_wr) mem[mem_addr] = mem_wdata;
            end else begin
                mem_ack   = 1'b0;
                wcnt++;
                have_hold = 1;
                hold_bus  = {mem_wr, mem_addr, mem_wdata};
            end
        end
        #1;
        if (reg_we) begin
            if (rq.size() == 0) begin
                check("unexpected_reg_we", {reg_sel, reg_wdata}, 48'h0);
            end else begin
                rw_t r;
                r = rq.pop_front();
                check("reg_sel", reg_sel, r.sel);
                check("reg_wdata", reg_wdata, r.data);
            end
            regs[reg_sel] = reg_wdata;
        end
        if (operand_valid) begin
            opv_cnt++;
            op_seen = operand_out;
        end
    end

    // Expected transfers and register writes, derived from the mask semantics.
    task automatic model(input vec_t v);
        logic [15:0] sp;
        logic [15:0] d;
        sp = v.sp_in;
        for (int i = 0; i < 16; i++) begin
            if (v.push_mask[i]) begin
                sp = sp - 16'd2;
                d = (i == 4) ? v.sp_in : (i == 15) ? v.operand_in : regs[i];
                model_mem[sp] = d;
                xq.push_back('{1'b1, sp, d});
            end
        end
        for (int i = 15; i >= 0; i--) begin
            if (v.pop_mask[i]) begin
                d = model_mem[sp];
                xq.push_back('{1'b0, sp, 16'd0});
                if (i != 5 && i != 15) rq.push_back('{4'(i), d});
                sp = sp + 16'd2;
            end
        end
    endtask

    task automatic launch(input vec_t v);
        @(negedge clk);
        waits      = v.waits;
        opv_cnt    = 0;
        push_mask  = v.push_mask;
        pop_mask   = v.pop_mask;
        sp_in      = v.sp_in;
        operand_in = v.operand_in;
        start      = 1'b1;
    endtask

    task automatic run(input vec_t v, input string tag);
        int done_cyc;
        model(v);
        launch(v);
        done_cyc = 0;
        for (int c = 1; c <= 300 && done_cyc == 0; c++) begin
            @(negedge clk);
            start = v.inject && (c == 2);
            if (start) begin
                push_mask = 16'hFFFF;
                pop_mask  = 16'hFFFF;
                sp_in     = 16'hAAAA;
            end
            #2;
            if (done) done_cyc = c;
        end
        start = 1'b0;
        check({tag, "_done_cycle"}, done_cyc, v.exp_cycles);
        check({tag, "_sp_out"}, sp_out, v.exp_sp);
        check({tag, "_sp_we_busy"}, {sp_we, busy}, 2'b11);
        @(negedge clk);
        #2;
        check({tag, "_after_done"}, {done, sp_we, busy, mem_req}, 4'b0000);
        check({tag, "_sp_held"}, sp_out, v.exp_sp);
        check({tag, "_xfers_left"}, xq.size(), 0);
        check({tag, "_regw_left"}, rq.size(), 0);
        check({tag, "_opv_pulses"}, opv_cnt, v.exp_opv);
        if (v.exp_opv != 0) check({tag, "_operand_out"}, op_seen, v.exp_op);
        push_mask = 16'd0;
        pop_mask  = 16'd0;
    endtask

    vec_t vecs[7];

    initial begin
        vec_t rv;
        bit   done_seen;
        vecs[0] = '{16'h01DF, 16'h0000, 16'h0100, 16'h0000, 0, 16'h00F0, 9, 0, 16'h0, 1'b1};
        vecs[1] = '{16'h0000, 16'h01EF, 16'h00F0, 16'h0000, 0, 16'h0100, 9, 0, 16'h0, 1'b0};
        vecs[2] = '{16'h4C00, 16'h0000, 16'h2000, 16'h0000, 2, 16'h1FFA, 10, 0, 16'h0, 1'b1};
        vecs[3] = '{16'h8000, 16'h0000, 16'h0000, 16'hBEEF, 0, 16'hFFFE, 2, 0, 16'h0, 1'b0};
        vecs[4] = '{16'h0000, 16'h8000, 16'hFFFE, 16'h0000, 0, 16'h0000, 2, 1, 16'hBEEF, 1'b0};
        vecs[5] = '{16'h0000, 16'h0000, 16'h1234, 16'h0000, 0, 16'h1234, 1, 0, 16'h0, 1'b0};
        vecs[6] = '{16'h0003, 16'h0003, 16'h0400, 16'h0000, 1, 16'h0400, 9, 0, 16'h0, 1'b1};

        for (int i = 0; i < 16; i++) regs[i] = 16'h0F00 + 16'(i);
        regs[0] = 16'h1111; regs[1] = 16'h2222; regs[2] = 16'h3333; regs[3] = 16'h4444;
        regs[4] = 16'h5555; regs[6] = 16'h6666; regs[7] = 16'h7777; regs[8] = 16'h8888;
        regs[10] = 16'hA0A0; regs[11] = 16'hB0B0; regs[14] = 16'hC0C0;

        repeat (3) @(negedge clk);
        #2;
        check("reset_ctrl", {busy, done, sp_we, mem_req, mem_wr, reg_we, operand_valid}, 7'd0);
        check("reset_data", {sp_out, mem_addr, operand_out}, 48'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) run(vecs[i], $sformatf("v%0d", i));
        check("push_r_bw_word", mem[16'h00F8], 16'h4444);
        check("push_r_sp_word", mem[16'h00F6], 16'h0100);
        check("wrap_word", mem[16'hFFFE], 16'hBEEF);

        // Reset while the second of three pushes is waiting for its ack.
        rv = '{16'h0007, 16'h0000, 16'h3000, 16'h0000, 2, 16'h2FFA, 10, 0, 16'h0, 1'b0};
        model(rv);
        launch(rv);
        done_seen = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 4) reset = 1'b1;
            #2;
            if (done) done_seen = 1;
        end
        check("rst_mid_ctrl", {mem_req, done, sp_we, busy}, 4'b0000);
        check("rst_mid_no_done", done_seen, 1'b0);
        check("rst_mid_item1", mem[16'h2FFE], 16'h1111);
        reset = 1'b0;
        xq.delete();
        rq.delete();
        rv = '{16'h0001, 16'h0000, 16'h3000, 16'h0000, 0, 16'h2FFE, 2, 0, 16'h0, 1'b0};
        run(rv, "post_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
